load_store_unit: RTL and testbench

//  Memory stage of the 16-bit MicroProcessor, directly upstream of the data memory.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/byte_lane_merge.sv | 34 +++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, default widths and the
// captured request record. The optional byte path is LSU_BYTE_ACCESS_EN.
package lsu_pkg;

    localparam int LSU_DATA_W = 16;
    localparam int LSU_ADDR_W = 16;
    localparam int LSU_TAG_W  = 3;
    localparam int LSU_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Request as latched in IDLE; held unchanged until the next accept.
    typedef struct packed {
        logic                  write;
        logic                  is_byte;
        logic                  hi;
        logic                  sgn;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic [LSU_TAG_W-1:0]  tag;
    } lsu_req_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte lane helper for the load/store unit (built only with LSU_BYTE_ACCESS_EN).
// Loads: pick the addressed lane and zero/sign extend it to a word.
// Stores: replace the addressed lane of an old word with the new byte.
`ifdef LSU_BYTE_ACCESS_EN
module byte_lane_merge
    import lsu_pkg::*;
(
    input  logic [LSU_DATA_W-1:0] word,
    input  logic                  hi,
    input  logic                  sgn,
    input  logic [7:0]            wbyte,
    output logic [LSU_DATA_W-1:0] load_val,
    output logic [LSU_DATA_W-1:0] store_val
);

    localparam int NUM_LANES = LSU_DATA_W / 8;

    logic [NUM_LANES-1:0][7:0] lanes_in;
    logic [NUM_LANES-1:0][7:0] lanes_out;
    logic [7:0]                lane;

    assign lanes_in = word;
    assign lane     = lanes_in[hi];
    assign load_val = {{(LSU_DATA_W-8){sgn & lane[7]}}, lane};

    // Each lane passes through unless it is the one being written.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lanes_out[i] = (i == int'(hi)) ? wbyte : lanes_in[i];
    end

    assign store_val = lanes_out;

endmodule
`endif

// File: rtl/load_store_unit.sv
// Memory stage: one request in, one data-memory access (two for a byte
// store read-modify-write), one response out. Addresses >= DEPTH fault
// without touching memory. Optional byte access: LSU_BYTE_ACCESS_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DEPTH  = LSU_DEPTH,
    parameter int TAG_W  = LSU_TAG_W
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_hi,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state, state_nx;
    lsu_req_t          req_q;
    logic              fault;
    logic              is_byte;
    logic [DATA_W-1:0] load_val;

    // Ready and valid come straight from state, so there is no
    // combinational path from resp_ready to req_ready.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign fault      = (32'(req_q.addr) >= 32'(DEPTH));

`ifdef LSU_BYTE_ACCESS_EN
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] byte_load;
    logic [DATA_W-1:0] byte_store;

    assign is_byte   = req_q.is_byte;
    // ACCESS extracts from the live read; MERGE inserts into the saved word.
    assign lane_word = (state == MERGE) ? old_q : mem_rdata;
    assign load_val  = is_byte ? byte_load : mem_rdata;

    byte_lane_merge u_merge (
        .word      (lane_word),
        .hi        (req_q.hi),
        .sgn       (req_q.sgn),
        .wbyte     (req_q.wdata[7:0]),
        .load_val  (byte_load),
        .store_val (byte_store)
    );

    // Old word for the read-modify-write, sampled during ACCESS.
    always_ff @(posedge clock) begin
        if (reset)
            old_q <= '0;
        else if (state == ACCESS)
            old_q <= mem_rdata;
    end
`else
    // Byte controls are captured but have no effect in the word-only build.
    logic lsu_cfg_unused;
    assign lsu_cfg_unused = ^{req_q.is_byte, req_q.hi, req_q.sgn};
    assign is_byte  = 1'b0;
    assign load_val = mem_rdata;
`endif

    // Next state and memory strobes; reset forces everything quiet.
    always_comb begin
        state_nx     = state;
        mem_address  = '0;
        mem_wdata    = '0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nx = ACCESS;
            end
            ACCESS: begin
                state_nx = RESP;
                if (!fault) begin
                    mem_address = req_q.addr;
                    if (!req_q.write) begin
                        mem_memread = 1'b1;
                    end else if (is_byte) begin
                        mem_memread = 1'b1;
                        state_nx    = MERGE;
                    end else begin
                        mem_memwrite = 1'b1;
                        mem_wdata    = req_q.wdata;
                    end
                end
            end
            MERGE: begin
`ifdef LSU_BYTE_ACCESS_EN
                mem_address  = req_q.addr;
                mem_memwrite = 1'b1;
                mem_wdata    = byte_store;
                state_nx     = RESP;
`else
                state_nx     = IDLE;
`endif
            end
            RESP: begin
                if (resp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (reset) begin
            mem_address  = '0;
            mem_wdata    = '0;
            mem_memread  = 1'b0;
            mem_memwrite = 1'b0;
            state_nx     = IDLE;
        end
    end

    // State, request capture and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            resp_data  <= '0;
            resp_tag   <= '0;
            resp_fault <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid)
                req_q <= '{write: req_write, is_byte: req_byte, hi: req_hi,
                           sgn: req_signed, addr: req_addr, wdata: req_wdata,
                           tag: req_tag};
            if (state == ACCESS) begin
                resp_tag   <= req_q.tag;
                resp_fault <= fault;
                resp_data  <= (fault || req_q.write) ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory
// and a word-array reference model of memory and responses.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_byte, req_hi, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  req_tag;
    logic        resp_valid, resp_ready, resp_fault;
    logic [15:0] resp_data;
    logic [2:0]  resp_tag;
    logic [15:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_memwrite, mem_memread;

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_hi(req_hi), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, write on posedge.
    logic [15:0] mem [16];
    assign mem_rdata = (mem_address < 16'd16) ? mem[mem_address[3:0]] : 16'hDEAD;
    always @(posedge clock) if (mem_memwrite && mem_address < 16'd16) mem[mem_address[3:0]] <= mem_wdata;

    int strobes = 0;
    int oob     = 0;
    int cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (mem_memread || mem_memwrite) strobes <= strobes + 1;
        if ((mem_memread || mem_memwrite) && mem_address >= 16'd16) oob <= oob + 1;
    end

    int nchk = 0;
    int nfail = 0;
    int last_acc = 0;
    int ref_mem [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what the access should return, how long it takes, and
    // what memory should hold afterwards.
    task automatic ref_model(input bit wr, input bit byt, input bit hi, input bit sgn,
                             input int a, input int wd,
                             output logic [15:0] d, output bit f, output int lat);
        bit eb;
        int b;
        eb = 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
        eb = byt;
`endif
        d = 16'd0; f = 1'b0; lat = 2;
        if (a >= 16) begin
            f = 1'b1;
        end else if (!wr) begin
            if (eb) begin
                b = hi ? ref_mem[a] / 256 : ref_mem[a] % 256;
                d = (sgn && b >= 128) ? 16'(b + 65280) : 16'(b);
            end else begin
                d = 16'(ref_mem[a]);
            end
        end else if (eb) begin
            lat = 3;
            if (hi) ref_mem[a] = (wd % 256) * 256 + ref_mem[a] % 256;
            else    ref_mem[a] = ref_mem[a] - ref_mem[a] % 256 + wd % 256;
        end else begin
            ref_mem[a] = wd;
        end
    endtask

    task automatic do_req(input bit wr, input bit byt, input bit hi, input bit sgn,
                          input logic [15:0] addr, input logic [15:0] wd, input logic [2:0] tag,
                          input int hold, input bit keep_valid, input int exp_gap);
        logic [15:0] ed;
        bit          ef;
        int          el, w, lat;
        ref_model(wr, byt, hi, sgn, int'(addr), int'(wd), ed, ef, el);
        req_write = wr; req_byte = byt; req_hi = hi; req_signed = sgn;
        req_addr = addr; req_wdata = wd; req_tag = tag; req_valid = 1'b1;
        resp_ready = (hold == 0);
        w = 0;
        while (!req_ready && w < 20) begin @(posedge clock); #1; w++; end
        if (!req_ready) begin
            check("accept_timeout", 32'(w), 32'(0));
            req_valid = 1'b0;
            return;
        end
        if (exp_gap > 0) check("accept_gap", 32'(cyc - last_acc), 32'(exp_gap));
        last_acc = cyc;
        lat = 0;
        do begin
            @(posedge clock); #1; lat++;
            if (lat == 1 && !keep_valid) req_valid = 1'b0;
        end while (!resp_valid && lat < 20);
        check("latency", 32'(lat), 32'(el));
        check("resp_data", 32'(resp_data), 32'(ed));
        check("resp_tag", 32'(resp_tag), 32'(tag));
        check("resp_fault", 32'(resp_fault), 32'(ef));
        repeat (hold) begin
            @(posedge clock); #1;
            check("hold_state", {29'd0, resp_valid, req_ready, resp_fault}, {29'd0, 1'b1, 1'b0, ef});
            check("hold_payload", {13'd0, resp_tag, resp_data}, {13'd0, tag, ed});
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("back_to_idle", {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] s0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_hi = 1'b0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
        check("reset_resp", {12'd0, resp_fault, resp_tag, resp_data}, 32'd0);
        check("reset_mem", {14'd0, mem_memread, mem_memwrite, mem_address | mem_wdata}, 32'd0);

        // Preload every word through the unit.
        for (int i = 0; i < 16; i++)
            do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'(i), 16'($urandom), 3'(i), 0, 1'b0, 0);

        // Word store then load with tag 5.
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'hBEEF, 3'd1, 0, 1'b0, 0);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'h0000, 3'd5, 0, 1'b0, 0);

        // Out-of-range accesses never strobe memory.
        s0 = 16'(strobes);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd16, 16'h0000, 3'd6, 0, 1'b0, 0);
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h5555, 3'd7, 0, 1'b0, 0);
        check("fault_no_strobe", 32'(strobes) - 32'(s0), 32'd0);

        // Response held off for 4 cycles.
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'h0000, 3'd2, 4, 1'b0, 0);

`ifdef LSU_BYTE_ACCESS_EN
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'h1280, 3'd0, 0, 1'b0, 0);
        do_req(1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 16'h00AB, 3'd1, 0, 1'b0, 0);
        check("byte_store_mem", 32'(mem[2]), 32'h0000AB80);
        do_req(1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'h0000, 3'd2, 0, 1'b0, 0);
        do_req(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'h0000, 3'd3, 0, 1'b0, 0);
        do_req(1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 16'h0000, 3'd4, 2, 1'b0, 0);
`endif

        // Back-to-back with req_valid held: one accept every 3 cycles.
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'd9,  16'h0A0A, 3'd1, 0, 1'b1, 0);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd9,  16'h0000, 3'd2, 0, 1'b1, 3);
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'd10, 16'h7777, 3'd3, 0, 1'b1, 3);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd10, 16'h0000, 3'd4, 0, 1'b0, 3);

        // Randomized traffic, some out of range, some held responses.
        for (int i = 0; i < 30; i++)
            do_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   16'($urandom_range(0, 19)), 16'($urandom), 3'($urandom),
                   int'($urandom_range(0, 2)), 1'b0, 0);

        // Load with nonzero data so the reset checks below are meaningful.
        do_req(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 16'hC3C3, 3'd6, 0, 1'b0, 0);
        do_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 16'h0000, 3'd7, 0, 1'b0, 0);

        // Reset during ACCESS of a word store: no write, outputs cleared.
        s0 = 16'(mem[7]);
        req_write = 1'b1; req_byte = 1'b0; req_addr = 16'd7; req_wdata = 16'h1234;
        req_tag = 3'd3; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("access_write_strobe", 32'(mem_memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_gates_write", 32'(mem_memwrite), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_access_ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
        check("rst_access_resp", {12'd0, resp_fault, resp_tag, resp_data}, 32'd0);
        check("rst_access_mem", {14'd0, mem_memread, mem_memwrite, mem_address | mem_wdata}, 32'd0);
        @(posedge clock); #1;
        check("rst_access_addr7", 32'(mem[7]), 32'(s0));

        // Reset while a response waits: response dropped.
        req_write = 1'b0; req_addr = 16'd7; req_tag = 3'd4; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("resp_waiting", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; resp_ready = 1'b1;
        check("rst_resp_dropped", {30'd0, req_ready, resp_valid}, 32'd2);

        // Final memory image and range safety.
        for (int i = 0; i < 16; i++)
            check("mem_image", 32'(mem[i]), 32'(ref_mem[i]));
        check("oob_strobes", 32'(oob), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
